mdio_phy_emulator: RTL and testbench

//  Clause-22 MDIO slave that emulates a PHY register file to an external station manager (STA).

---
 rtl/mdio_phy_emulator_pkg.sv | 27 ++
 rtl/mdio_phy_emulator_regfile.sv | 52 +++++
 rtl/mdio_phy_emulator.sv | 160 ++++++++++++++++
 tb/tb_mdio_phy_emulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_phy_emulator_pkg.sv
// Shared constants and state encoding for the clause-22 MDIO PHY emulator.
// Frame bit indices are the posedge on which bit k is sampled.
package mdio_phy_emulator_pkg;

    localparam int REG_W = 16;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] K_OP_LAST  = 5'd3;
    localparam logic [4:0] K_PHY_LAST = 5'd8;
    localparam logic [4:0] K_REG_LAST = 5'd13;
    localparam logic [4:0] K_TA_FIRST = 5'd14;
    localparam logic [4:0] K_TA_LAST  = 5'd15;
    localparam logic [4:0] K_LAST     = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } mdio_state_e;

endpackage

// File: rtl/mdio_phy_emulator_regfile.sv
// Emulated PHY register storage: masked writes, soft-reset reload from init
// values, combinational read (0 outside the implemented range).
module mdio_phy_emulator_regfile
    import mdio_phy_emulator_pkg::*;
#(
    parameter int                        NUM_REGS = 32,
    parameter logic [REG_W*NUM_REGS-1:0] REG_INIT = '0,
    parameter logic [REG_W*NUM_REGS-1:0] WR_MASK  = '1
) (
    input  logic             mdc,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [4:0]       raddr,
    output logic [REG_W-1:0] rdata,
    output logic [REG_W-1:0] wr_result
);

    logic [REG_W-1:0] regs [NUM_REGS];
    logic [REG_W-1:0] cur;
    logic [REG_W-1:0] mask;
    logic             soft_rst;

    always_comb begin
        rdata = '0;
        cur   = '0;
        mask  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 5'(i)) rdata = regs[i];
            if (waddr == 5'(i)) begin
                cur  = regs[i];
                mask = WR_MASK[REG_W*i +: REG_W];
            end
        end
    end

    // Soft reset ignores the mask: bit 15 of reg 0 is self-clearing.
    assign soft_rst  = we && (waddr == 5'd0) && wdata[15];
    assign wr_result = soft_rst ? REG_INIT[REG_W-1:0] : ((cur & ~mask) | (wdata & mask));

    always_ff @(posedge mdc) begin
        if (rst || soft_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT[REG_W*i +: REG_W];
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == 5'(i)) regs[i] <= wr_result;
            end
        end
    end

endmodule

// File: rtl/mdio_phy_emulator.sv
// Clause-22 MDIO slave emulating a PHY register file; frame FSM, shifters,
// pad control and write-notify strobe, all on mdc.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | counting preamble ones; a 0 after a full preamble is ST bit 0
//   S_ST    | k=1, second start bit must be 1
//   S_OP    | k=2..3, opcode; anything but read/write aborts
//   S_PHYAD | k=4..8, PHY address shift
//   S_REGAD | k=9..13, register address shift
//   S_TA    | k=14..15, turnaround; read response starts driving at k=14
//   S_DATA  | k=16..31, data shift in (write) or out (read)
module mdio_phy_emulator
    import mdio_phy_emulator_pkg::*;
#(
    parameter logic [4:0]                PHY_ADDR     = 5'd4,
    parameter int                        NUM_REGS     = 32,
    parameter logic [REG_W*NUM_REGS-1:0] REG_INIT     = '0,
    parameter logic [REG_W*NUM_REGS-1:0] WR_MASK      = '1,
    parameter int                        PREAMBLE_MIN = 32,
    parameter bit                        BCAST_EN     = 1'b1
) (
    input  logic        mdc,
    input  logic        rst,
    input  logic        mdio_i,
    output logic        mdio_t,
    output logic        mdio_o,
    output logic        busy,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    mdio_state_e      state, state_nxt;
    logic [5:0]       ones_cnt;
    logic [4:0]       bit_cnt;
    logic [1:0]       op_sr;
    logic [4:0]       phy_sr;
    logic [4:0]       reg_sr;
    logic [14:0]      data_sr;
    logic [REG_W-1:0] rd_sr;
    logic [REG_W-1:0] rdata;
    logic [REG_W-1:0] wr_result;

    logic is_read, is_write, addr_match, addr_ok;
    logic busy_nxt, mdio_t_nxt, mdio_o_nxt;
    logic rd_load, rd_shift, wr_accept;

    assign is_read    = (op_sr == OP_READ);
    assign is_write   = (op_sr == OP_WRITE);
    assign addr_match = (phy_sr == PHY_ADDR) || (BCAST_EN && is_write && (phy_sr == 5'd0));
    assign addr_ok    = ({1'b0, reg_sr} < 6'(NUM_REGS));

    always_ff @(posedge mdc) begin
        if (rst) begin
            state    <= S_IDLE;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            op_sr    <= '0;
            phy_sr   <= '0;
            reg_sr   <= '0;
            data_sr  <= '0;
            rd_sr    <= '0;
            mdio_t   <= 1'b0;
            mdio_o   <= 1'b0;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= (state == S_IDLE) ? 5'd1 : bit_cnt + 5'd1;

            // Any frame activity (including the start bit) restarts the preamble count.
            if (state == S_IDLE && state_nxt == S_IDLE && mdio_i)
                ones_cnt <= (ones_cnt == PRE_MIN) ? ones_cnt : ones_cnt + 6'd1;
            else
                ones_cnt <= '0;

            if (state == S_OP)    op_sr   <= {op_sr[0], mdio_i};
            if (state == S_PHYAD) phy_sr  <= {phy_sr[3:0], mdio_i};
            if (state == S_REGAD) reg_sr  <= {reg_sr[3:0], mdio_i};
            if (state == S_DATA)  data_sr <= {data_sr[13:0], mdio_i};

            if (rd_load)       rd_sr <= rdata;
            else if (rd_shift) rd_sr <= {rd_sr[REG_W-2:0], 1'b0};

            mdio_t <= mdio_t_nxt;
            mdio_o <= mdio_o_nxt;
            busy   <= busy_nxt;
            wr_stb <= wr_accept;
            if (wr_accept) begin
                wr_addr <= reg_sr;
                wr_data <= wr_result;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!mdio_i && ones_cnt == PRE_MIN) state_nxt = S_ST;
            S_ST:    state_nxt = mdio_i ? S_OP : S_IDLE;
            S_OP: begin
                if (bit_cnt == K_OP_LAST) begin
                    if ({op_sr[0], mdio_i} == OP_READ || {op_sr[0], mdio_i} == OP_WRITE)
                        state_nxt = S_PHYAD;
                    else
                        state_nxt = S_IDLE;
                end
            end
            S_PHYAD: if (bit_cnt == K_PHY_LAST) state_nxt = S_REGAD;
            S_REGAD: if (bit_cnt == K_REG_LAST) state_nxt = S_TA;
            S_TA:    if (bit_cnt == K_TA_LAST)  state_nxt = S_DATA;
            S_DATA:  if (bit_cnt == K_LAST)     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt   = (state != S_IDLE) && (state_nxt != S_IDLE);
        mdio_t_nxt = mdio_t;
        mdio_o_nxt = mdio_o;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;
        wr_accept  = 1'b0;
        if (state == S_TA && bit_cnt == K_TA_FIRST) begin
            if (is_read && addr_match) begin
                mdio_t_nxt = 1'b1;
                mdio_o_nxt = 1'b0;
                rd_load    = 1'b1;
            end
        end else if (state == S_DATA && bit_cnt == K_LAST) begin
            mdio_t_nxt = 1'b0;
            mdio_o_nxt = 1'b0;
            wr_accept  = is_write && addr_match && addr_ok;
        end else if (mdio_t) begin
            mdio_o_nxt = rd_sr[REG_W-1];
            rd_shift   = 1'b1;
        end
    end

    mdio_phy_emulator_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_INIT (REG_INIT),
        .WR_MASK  (WR_MASK)
    ) u_regfile (
        .mdc       (mdc),
        .rst       (rst),
        .we        (wr_accept),
        .waddr     (reg_sr),
        .wdata     ({data_sr, mdio_i}),
        .raddr     (reg_sr),
        .rdata     (rdata),
        .wr_result (wr_result)
    );

endmodule

// File: tb/tb_mdio_phy_emulator.sv
// Directed bench: drives MDIO frames as the station manager and checks the
// emulator's pad, busy and write-notify behaviour against hand-computed values.
module tb_mdio_phy_emulator;

    localparam logic [127:0] INIT = {16'h0000, 16'h0000, 16'h0000, 16'h0101,
                                     16'hD023, 16'h0000, 16'h0000, 16'h1140};
    localparam logic [127:0] MASK = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0F0F,
                                     16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    logic mdc = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;
    logic sel = 1'b0;

    logic a_mdio_i, a_mdio_t, a_mdio_o, a_busy, a_wr_stb;
    logic [4:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic b_mdio_i, b_mdio_t, b_mdio_o, b_busy, b_wr_stb;
    logic [4:0]  b_wr_addr;
    logic [15:0] b_wr_data;

    int n_chk = 0;
    int n_bad = 0;

    logic t_log [0:33];
    logic o_log [0:33];
    logic b_log [0:33];
    logic s_log [0:33];
    logic [15:0] rd_val;
    int          stb_cnt;
    logic [4:0]  cap_wa;
    logic [15:0] cap_wd;

    always #5 mdc = ~mdc;

    assign a_mdio_i = sel ? 1'b1 : line;
    assign b_mdio_i = sel ? line : 1'b1;

    mdio_phy_emulator #(
        .PHY_ADDR(5'd4), .NUM_REGS(8), .REG_INIT(INIT), .WR_MASK(MASK),
        .PREAMBLE_MIN(32), .BCAST_EN(1'b1)
    ) dut_a (
        .mdc(mdc), .rst(rst), .mdio_i(a_mdio_i), .mdio_t(a_mdio_t), .mdio_o(a_mdio_o),
        .busy(a_busy), .wr_stb(a_wr_stb), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    mdio_phy_emulator #(
        .PHY_ADDR(5'd4), .NUM_REGS(8), .REG_INIT(INIT), .WR_MASK(MASK),
        .PREAMBLE_MIN(0), .BCAST_EN(1'b1)
    ) dut_b (
        .mdc(mdc), .rst(rst), .mdio_i(b_mdio_i), .mdio_t(b_mdio_t), .mdio_o(b_mdio_o),
        .busy(b_busy), .wr_stb(b_wr_stb), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preamble(input int n, input bit lead_zero);
        if (lead_zero) begin
            @(negedge mdc);
            line = 1'b0;
        end
        repeat (n) begin
            @(negedge mdc);
            line = 1'b1;
        end
    endtask

    task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] d, input int abort_k, input int trail);
        logic [31:0] bits;
        logic [1:0]  ta;
        ta   = (op == 2'b01) ? 2'b10 : 2'b11;
        bits = {2'b01, op, phy, ra, ta, (op == 2'b01) ? d : 16'hFFFF};
        for (int k = 0; k < 34; k++) begin
            t_log[k] = 1'b0;
            o_log[k] = 1'b0;
            b_log[k] = 1'b0;
            s_log[k] = 1'b0;
        end
        stb_cnt = 0;
        rd_val  = '0;
        for (int k = 0; k < 32 + trail; k++) begin
            @(negedge mdc);
            line = (k < 32) ? bits[31-k] : 1'b1;
            rst  = (k == abort_k);
            @(posedge mdc);
            #1;
            t_log[k] = sel ? b_mdio_t : a_mdio_t;
            o_log[k] = sel ? b_mdio_o : a_mdio_o;
            b_log[k] = sel ? b_busy   : a_busy;
            s_log[k] = sel ? b_wr_stb : a_wr_stb;
            if (k >= 15 && k <= 30) rd_val[30-k] = o_log[k];
            if (s_log[k]) begin
                stb_cnt++;
                cap_wa = sel ? b_wr_addr : a_wr_addr;
                cap_wd = sel ? b_wr_data : a_wr_data;
            end
            if (k == abort_k) begin
                @(negedge mdc);
                rst = 1'b0;
                break;
            end
        end
    endtask

    function automatic logic any_t();
        logic r;
        r = 1'b0;
        for (int k = 0; k < 34; k++) r |= t_log[k];
        return r;
    endfunction

    function automatic logic any_busy();
        logic r;
        r = 1'b0;
        for (int k = 0; k < 34; k++) r |= b_log[k];
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge mdc);
        #1;
        chk("rst_mdio_t", 32'(a_mdio_t), 32'd0);
        chk("rst_mdio_o", 32'(a_mdio_o), 32'd0);
        chk("rst_busy",   32'(a_busy),   32'd0);
        chk("rst_wr_stb", 32'(a_wr_stb), 32'd0);
        chk("rst_wr_addr", 32'(a_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(a_wr_data), 32'd0);
        chk("rst_b_mdio_t", 32'(b_mdio_t), 32'd0);
        @(negedge mdc);
        rst = 1'b0;

        // Read reg 3 with a full preamble
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd3, 16'h0000, -1, 2);
        chk("rd3_busy_k0",  32'(b_log[0]),  32'd0);
        chk("rd3_busy_k1",  32'(b_log[1]),  32'd1);
        chk("rd3_t_k13",    32'(t_log[13]), 32'd0);
        chk("rd3_t_k14",    32'(t_log[14]), 32'd1);
        chk("rd3_ta2",      32'(o_log[14]), 32'd0);
        chk("rd3_data",     32'(rd_val),    32'hD023);
        chk("rd3_t_k30",    32'(t_log[30]), 32'd1);
        chk("rd3_t_k31",    32'(t_log[31]), 32'd0);
        chk("rd3_busy_k30", 32'(b_log[30]), 32'd1);
        chk("rd3_busy_k31", 32'(b_log[31]), 32'd0);

        // Masked write to reg 4
        preamble(32, 1'b1);
        frame(2'b01, 5'd4, 5'd4, 16'hFFFF, -1, 2);
        chk("wr4_t_any",   32'(any_t()),   32'd0);
        chk("wr4_stb_k30", 32'(s_log[30]), 32'd0);
        chk("wr4_stb_k31", 32'(s_log[31]), 32'd1);
        chk("wr4_stb_cnt", 32'(stb_cnt),   32'd1);
        chk("wr4_addr",    32'(cap_wa),    32'd4);
        chk("wr4_data",    32'(cap_wd),    32'h0F0F);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd4, 16'h0000, -1, 2);
        chk("rd4_after_wr", 32'(rd_val), 32'h0F0F);

        // Broadcast: read at PHY 0 ignored, write at PHY 0 accepted
        preamble(32, 1'b1);
        frame(2'b10, 5'd0, 5'd3, 16'h0000, -1, 2);
        chk("bc_rd_t_any", 32'(any_t()), 32'd0);
        preamble(32, 1'b1);
        frame(2'b01, 5'd0, 5'd5, 16'h1234, -1, 2);
        chk("bc_wr_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("bc_wr_data",    32'(cap_wd),  32'h1234);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd5, 16'h0000, -1, 2);
        chk("rd5_after_bc", 32'(rd_val), 32'h1234);

        // Foreign PHY write must not land
        preamble(32, 1'b1);
        frame(2'b01, 5'd7, 5'd5, 16'h5678, -1, 2);
        chk("other_phy_stb", 32'(stb_cnt), 32'd0);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd5, 16'h0000, -1, 2);
        chk("rd5_after_other", 32'(rd_val), 32'h1234);

        // Register beyond NUM_REGS: write dropped, read drives zeros
        preamble(32, 1'b1);
        frame(2'b01, 5'd4, 5'd9, 16'h5555, -1, 2);
        chk("wr9_stb_cnt", 32'(stb_cnt), 32'd0);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd9, 16'h0000, -1, 2);
        chk("rd9_t_k14", 32'(t_log[14]), 32'd1);
        chk("rd9_data",  32'(rd_val),    32'h0000);

        // Short preamble: ignored frame
        preamble(31, 1'b1);
        frame(2'b10, 5'd4, 5'd3, 16'h0000, -1, 2);
        chk("pre31_busy_any", 32'(any_busy()), 32'd0);
        chk("pre31_t_any",    32'(any_t()),    32'd0);

        // Illegal opcode aborts after k=3
        preamble(32, 1'b1);
        frame(2'b11, 5'd4, 5'd3, 16'h0000, -1, 2);
        chk("op11_busy_k2", 32'(b_log[2]), 32'd1);
        chk("op11_busy_k3", 32'(b_log[3]), 32'd0);
        chk("op11_t_any",   32'(any_t()),  32'd0);

        // Soft reset via reg 0 bit 15
        preamble(32, 1'b1);
        frame(2'b01, 5'd4, 5'd0, 16'h8000, -1, 2);
        chk("srst_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("srst_wr_addr", 32'(cap_wa),  32'd0);
        chk("srst_wr_data", 32'(cap_wd),  32'h1140);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd4, 16'h0000, -1, 2);
        chk("srst_rd4", 32'(rd_val), 32'h0101);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd0, 16'h0000, -1, 2);
        chk("srst_rd0", 32'(rd_val), 32'h1140);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd5, 16'h0000, -1, 2);
        chk("srst_rd5", 32'(rd_val), 32'h0000);

        // Reset in the middle of a read
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd3, 16'h0000, 20, 0);
        chk("abort_t_k19",    32'(t_log[19]), 32'd1);
        chk("abort_t_k20",    32'(t_log[20]), 32'd0);
        chk("abort_busy_k20", 32'(b_log[20]), 32'd0);
        preamble(32, 1'b1);
        frame(2'b10, 5'd4, 5'd3, 16'h0000, -1, 2);
        chk("post_abort_rd3", 32'(rd_val), 32'hD023);

        // Preamble suppression: back-to-back frames on the second instance
        sel = 1'b1;
        repeat (2) @(negedge mdc);
        frame(2'b01, 5'd4, 5'd2, 16'hABCD, -1, 0);
        chk("b2b_wr_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("b2b_wr_data",    32'(cap_wd),  32'hABCD);
        frame(2'b10, 5'd4, 5'd2, 16'h0000, -1, 0);
        chk("b2b_rd2",     32'(rd_val),    32'hABCD);
        chk("b2b_t_k14",   32'(t_log[14]), 32'd1);
        frame(2'b10, 5'd4, 5'd3, 16'h0000, -1, 2);
        chk("b2b_rd3",     32'(rd_val),    32'hD023);
        chk("b2b_t_k31",   32'(t_log[31]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
